// File: rtl/seg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_driver: 8-digit multiplexed 7-segment driver for two countdowns  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module seg_scan_driver #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] car_cnt,
  input  logic [6:0] ped_cnt,
  input  logic       en,
  output logic [7:0] dis,
  output logic [7:0] sel
);

  localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  logic [SLOT_W-1:0]  slot_q,   slot_d;
  logic [2:0]         idx_q,    idx_d;
  logic [FRAME_W-1:0] frame_q,  frame_d;
  logic               phase_q,  phase_d;
  logic               first_q,  first_d;
  logic [6:0]         car_sh_q, car_sh_d;
  logic [6:0]         ped_sh_q, ped_sh_d;
  logic [7:0]         dis_q,    dis_d;
  logic [7:0]         sel_q,    sel_d;
  logic               slot_wrap;
  logic               frame_wrap;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Dash overrides blink; blink overrides the tens leading-zero rule.
  function automatic logic [7:0] digit_code(input logic [6:0] v,
                                            input logic       is_tens,
                                            input logic       ph);
    logic [7:0] s;
    if (v >= 7'd100) begin
      s = SEG_DASH;
    end else if (v <= 7'd3 && ph) begin
      s = SEG_BLANK;
    end else if (is_tens) begin
      s = (v < 7'd10) ? SEG_BLANK : seg_of(4'(v / 7'd10));
    end else begin
      s = seg_of(4'(v % 7'd10));
    end
    return s;
  endfunction

  always_comb begin
    slot_wrap  = (slot_q == SLOT_LAST);
    frame_wrap = slot_wrap && (idx_q == 3'd7);

    slot_d  = slot_wrap ? '0 : slot_q + SLOT_W'(1);
    idx_d   = slot_wrap ? idx_q + 3'd1 : idx_q;
    frame_d = frame_q;
    phase_d = phase_q;
    if (frame_wrap) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FRAME_W'(1);
      end
    end

    // The first edge out of reset is a frame start as well.
    first_d  = 1'b0;
    car_sh_d = (frame_wrap || first_q) ? car_cnt : car_sh_q;
    ped_sh_d = (frame_wrap || first_q) ? ped_cnt : ped_sh_q;

    sel_d = 8'hFF;
    dis_d = SEG_BLANK;
    if (en && !first_q) begin
      sel_d = ~(8'd1 << idx_q);
      case (idx_q)
        3'd0:    dis_d = digit_code(ped_sh_q, 1'b0, phase_q);
        3'd1:    dis_d = digit_code(ped_sh_q, 1'b1, phase_q);
        3'd6:    dis_d = digit_code(car_sh_q, 1'b0, phase_q);
        3'd7:    dis_d = digit_code(car_sh_q, 1'b1, phase_q);
        default: dis_d = SEG_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      idx_q    <= '0;
      frame_q  <= '0;
      phase_q  <= 1'b0;
      first_q  <= 1'b1;
      car_sh_q <= '0;
      ped_sh_q <= '0;
      dis_q    <= SEG_BLANK;
      sel_q    <= 8'hFF;
    end else begin
      slot_q   <= slot_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      phase_q  <= phase_d;
      first_q  <= first_d;
      car_sh_q <= car_sh_d;
      ped_sh_q <= ped_sh_d;
      dis_q    <= dis_d;
      sel_q    <= sel_d;
    end
  end

  assign dis = dis_q;
  assign sel = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seg_scan_driver: reference-model bench for seg_scan_driver             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_seg_scan_driver;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = 8 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [6:0] car_cnt = '0;
  logic [6:0] ped_cnt = '0;
  logic [7:0] dis;
  logic [7:0] sel;

  int checks   = 0;
  int failures = 0;
  int k        = 0;   // edges since reset release
  int sh_car   = 0;
  int sh_ped   = 0;
  int cur_car  = 0;
  int cur_ped  = 0;
  logic cur_en = 1'b1;

  logic [7:0] enc [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                           8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk     (clk),
    .rst     (rst),
    .car_cnt (car_cnt),
    .ped_cnt (ped_cnt),
    .en      (en),
    .dis     (dis),
    .sel     (sel)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] code(input int v, input bit tens, input int ph);
    if (v >= 100) return 8'hBF;
    if (v <= 3 && ph == 1) return 8'hFF;
    if (tens) return (v < 10) ? 8'hFF : enc[v / 10];
    return enc[v % 10];
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict the registered outputs, then compare.
  task automatic step(input logic r, input logic e, input int c, input int p);
    logic [7:0] es;
    logic [7:0] ed;
    int idx;
    int ph;
    @(negedge clk);
    rst = r; en = e; car_cnt = 7'(c); ped_cnt = 7'(p);
    es = 8'hFF; ed = 8'hFF;
    if (r) begin
      k = 0; sh_car = 0; sh_ped = 0;
    end else begin
      k++;
      if (k > 1 && e) begin
        idx = ((k - 1) / SD) % 8;
        ph  = (((k - 1) / FRAME) / BF) % 2;
        es  = 8'hFF ^ (8'h01 << idx);
        case (idx)
          0:       ed = code(sh_ped, 1'b0, ph);
          1:       ed = code(sh_ped, 1'b1, ph);
          6:       ed = code(sh_car, 1'b0, ph);
          7:       ed = code(sh_car, 1'b1, ph);
          default: ed = 8'hFF;
        endcase
      end
      if (k == 1 || k % FRAME == 0) begin
        sh_car = c; sh_ped = p;
      end
    end
    @(posedge clk);
    #1;
    check8("sel", sel, es);
    check8("dis", dis, ed);
  endtask

  task automatic run(input int n, input logic e, input int c, input int p);
    for (int i = 0; i < n; i++) step(1'b0, e, c, p);
  endtask

  initial begin
    // Reset held three cycles, then release with ped=8
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 57, 8);
    step(1'b0, 1'b1, 57, 8);
    step(1'b0, 1'b1, 57, 8);
    check8("first_digit_sel", sel, 8'hFE);
    check8("first_digit_dis", dis, 8'h80);
    run(2 * FRAME, 1'b1, 57, 8);

    // Out-of-range car value across both blink phases
    run(4 * FRAME, 1'b1, 120, 8);

    // Mid-frame ped change lands in the next frame only
    while (((k / SD) % 8) != 0) step(1'b0, 1'b1, 50, 12);
    while (((k / SD) % 8) != 3) step(1'b0, 1'b1, 50, 12);
    run(2 * FRAME, 1'b1, 50, 34);

    // Blinking ped value with steady car value
    run(8 * FRAME, 1'b1, 50, 2);

    // Enable drop mid-slot, then resume
    while ((k % SD) != 1) step(1'b0, 1'b1, 99, 0);
    run(5, 1'b0, 99, 0);
    run(FRAME, 1'b1, 99, 0);

    // Reset mid-frame
    run(7, 1'b1, 3, 45);
    step(1'b1, 1'b1, 3, 45);
    check8("midframe_reset_sel", sel, 8'hFF);
    run(3 * FRAME, 1'b1, 3, 45);

    // Randomized traffic
    cur_car = 57; cur_ped = 8; cur_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0)
        cur_car = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 127));
      if ($urandom_range(0, 39) == 0)
        cur_ped = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 127));
      if ($urandom_range(0, 59) == 0) cur_en = ~cur_en;
      step(($urandom_range(0, 799) == 0) ? 1'b1 : 1'b0, cur_en, cur_car, cur_ped);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 50000, SHALL set the clock cycles per digit slot.
REQ-002 Parameter BLINK_FRAMES, default 125, SHALL set the full scan frames per blink half-period.
REQ-003 clk  in  1  SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-004 rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 car_cnt  in  7  SHALL carry the vehicle countdown value, unsigned binary.
REQ-006 ped_cnt  in  7  SHALL carry the pedestrian countdown value, unsigned binary.
REQ-007 en  in  1  SHALL enable the display when 1.
REQ-008 dis  out  8  SHALL drive active-low segments {dp,g,f,e,d,c,b,a}, registered.
REQ-009 sel  out  8  SHALL drive active-low one-hot digit select (bit i = digit i), registered.

Function
REQ-010 The slot counter SHALL count 0..SCAN_DIV-1 and wrap; at count SCAN_DIV-1 the digit index (3 bits) SHALL increment mod 8.
REQ-011 On the 7->0 index wrap (frame start), car_cnt and ped_cnt SHALL be latched into shadow registers; the display SHALL use only shadow values, so mid-frame input changes do not show until the next frame.
REQ-012 The frame counter SHALL count 0..BLINK_FRAMES-1 on each frame start; on wrap, blink_phase SHALL toggle.
REQ-013 dis/sel SHALL be registered from the current index, shadows and phase, and therefore lag the index by exactly 1 cycle.
REQ-014 Digit map: 0 = ped units, 1 = ped tens, 6 = car units, 7 = car tens, 2-5 = blank (sel bit low, dis=8'hFF).
REQ-015 Value split SHALL be tens = v/10 and units = v%10 for v<=99.
REQ-016 Encoding: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF; dp always off.
REQ-017 Leading-zero suppression: the tens digit SHALL be blank when v<10; units SHALL always show (v=0 shows C0).
REQ-018 Out of range: v>=100 SHALL drive dash (8'hBF) on both digits of that counter, with no blink.
REQ-019 Blink: when v<=3 and blink_phase=1, both digits of that counter SHALL be blank; otherwise they are normal.
REQ-020 When en=0, sel SHALL be 8'hFF and dis 8'hFF on the next cycle; the counters, shadow latching and blink phase SHALL keep running.
REQ-021 Exactly one sel bit SHALL be low at any time when en=1 and not in reset.

Reset
REQ-022 With rst=1 at an edge, the following SHALL reset: slot counter=0, index=0, frame counter=0, blink_phase=0, shadows=0, sel=8'hFF, dis=8'hFF.
REQ-023 Reset SHALL take priority over en and all counting.
REQ-024 Reset asserted mid-frame SHALL return outputs to the reset values at the next edge.
REQ-025 On the first edge after release, index 0 SHALL be current and the shadows SHALL latch inputs (frame start); sel=8'hFE SHALL appear on the following edge.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-026 Reset/release: rst high 3 cycles -> sel=FF, dis=FF; release with ped_cnt=8 -> sel=FE, dis=80 two edges later.
REQ-027 car_cnt=57, ped_cnt=8, one frame -> idx7 dis=92, idx6 F8, idx1 FF, idx0 80, idx2-5 FF, with sel one-hot low each slot.
REQ-028 car_cnt=120 -> idx7 and idx6 dis=BF in every frame, no blanking.
REQ-029 ped_cnt changes 12->34 at idx3 -> rest of frame shows 12; from the next idx0 the display shows 34.
REQ-030 ped_cnt=2 -> idx0 dis=A4 for 2 frames, FF for 2 frames, alternating; car digits with car_cnt=50 are unaffected.
REQ-031 en 1->0 mid-slot -> sel=FF, dis=FF next cycle; en back to 1 -> scanning resumes at the current index with no counter reset.
